// File: rtl/bj_card_sram_reader.sv
// bj_card_sram_reader
// Read-only master on the fabric side of the card SRAM. After the HPS
// raises init_done[0], the block walks the deck words from address 0,
// unpacks each 32-bit word LSB-first into 8-bit cards, and hands them to
// the blackjack engine. A zero byte marks end-of-deck and is never emitted.
//
// Card handshake (valid/ready):
//   card_valid is registered and, once high, holds card_data stable until
//   the cycle in which card_ready is also high. That cycle is the transfer.
//   card_valid is always low in the cycle after a transfer, so the consumer
//   sees at most one card every two cycles. card_ready may toggle freely
//   and has no effect while card_valid is low.
module bj_card_sram_reader #(
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        init_done,
    input  logic [ADDR_W:0]   num_words,
    input  logic              rewind,
    output logic [ADDR_W-1:0] sram_address,
    output logic              sram_clken,
    output logic              sram_chipselect,
    output logic              sram_write,
    output logic [31:0]       sram_writedata,
    output logic [3:0]        sram_byteenable,
    input  logic [31:0]       sram_readdata,
    output logic              card_valid,
    output logic [7:0]        card_data,
    input  logic              card_ready,
    output logic [ADDR_W+1:0] card_index,
    output logic              deck_done,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_STREAM = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // A full memory: num_words values above this are clamped to it.
    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    // Latency counter reaches this value in the cycle readdata is valid.
    localparam logic [1:0]      LAT_CNT = 2'(RD_LAT);

    state_t            r_state;
    logic              r_init_d;
    logic [ADDR_W-1:0] r_addr;
    logic              r_clken;
    logic              r_cs;
    logic [31:0]       r_word;
    logic [1:0]        r_byte_sel;
    logic [1:0]        r_lat_cnt;
    logic              r_valid;
    logic [7:0]        r_data;
    logic [ADDR_W+1:0] r_index;
    logic              r_done;

    logic              w_start;
    logic [ADDR_W-1:0] w_last_addr;
    logic [7:0]        w_cur_byte;
    logic              w_unused;

    // Only bit 0 of the PIO carries meaning.
    assign w_unused = ^init_done[7:1];

    // Rising edge of the deck-loaded flag, same clock domain as the PIO.
    assign w_start = init_done[0] & ~r_init_d;

    // Address of the final deck word, with oversize counts clamped to the
    // top of memory so the walk never wraps back to address 0.
    always_comb begin
        w_last_addr = ADDR_W'(num_words - 1'b1);
        if (num_words > DEPTH) begin
            w_last_addr = '1;
        end
    end

    // Byte of the held word selected for presentation, LSB first.
    always_comb begin
        w_cur_byte = r_word[7:0];
        case (r_byte_sel)
            2'd0:    w_cur_byte = r_word[7:0];
            2'd1:    w_cur_byte = r_word[15:8];
            2'd2:    w_cur_byte = r_word[23:16];
            default: w_cur_byte = r_word[31:24];
        endcase
    end

    // Reader FSM: issue one read, wait out the latency, stream four bytes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_init_d   <= 1'b0;
            r_addr     <= '0;
            r_clken    <= 1'b0;
            r_cs       <= 1'b0;
            r_word     <= '0;
            r_byte_sel <= '0;
            r_lat_cnt  <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_index    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_clken  <= 1'b1;
            r_init_d <= init_done[0];
            // Chipselect is a single-cycle strobe raised on entry to ISSUE.
            r_cs     <= 1'b0;
            if (rewind) begin
                // Abort: any read in flight is dropped by leaving WAIT.
                r_state <= S_IDLE;
                r_valid <= 1'b0;
                r_done  <= 1'b0;
                r_addr  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            if (num_words == '0) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_addr  <= '0;
                                r_index <= '0;
                                r_cs    <= 1'b1;
                                r_state <= S_ISSUE;
                            end
                        end
                    end
                    S_ISSUE: begin
                        r_lat_cnt <= 2'd1;
                        r_state   <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (r_lat_cnt == LAT_CNT) begin
                            // Byte 0 is presented straight from the bus so
                            // the word-to-word overhead stays at 1+RD_LAT.
                            r_word     <= sram_readdata;
                            r_byte_sel <= 2'd0;
                            if (sram_readdata[7:0] == 8'h00) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_valid <= 1'b1;
                                r_data  <= sram_readdata[7:0];
                                r_state <= S_STREAM;
                            end
                        end else begin
                            r_lat_cnt <= r_lat_cnt + 2'd1;
                        end
                    end
                    S_STREAM: begin
                        if (r_valid) begin
                            if (card_ready) begin
                                r_valid <= 1'b0;
                                r_index <= r_index + 1'b1;
                                if (r_byte_sel != 2'd3) begin
                                    r_byte_sel <= r_byte_sel + 2'd1;
                                end else if (r_addr == w_last_addr) begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_addr  <= r_addr + 1'b1;
                                    r_cs    <= 1'b1;
                                    r_state <= S_ISSUE;
                                end
                            end
                        end else if (w_cur_byte == 8'h00) begin
                            // End-of-deck marker: finish without emitting it.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_valid <= 1'b1;
                            r_data  <= w_cur_byte;
                        end
                    end
                    S_DONE: begin
                        if (!init_done[0]) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign sram_address    = r_addr;
    assign sram_clken      = r_clken;
    assign sram_chipselect = r_cs;
    assign sram_write      = 1'b0;
    assign sram_writedata  = 32'h0000_0000;
    assign sram_byteenable = 4'hF;
    assign card_valid      = r_valid;
    assign card_data       = r_data;
    assign card_index      = r_index;
    assign deck_done       = r_done;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_bj_card_sram_reader.sv
// Bench for bj_card_sram_reader: three instances (RD_LAT 1, 2, 3) share all
// inputs; each has its own SRAM model of matching latency that returns junk
// on every cycle that is not the answer to a chipselect.
module tb_bj_card_sram_reader;
    localparam int ADDR_W = 9;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n = 1'b0;
    logic [7:0]        init_done = 8'h00;
    logic [ADDR_W:0]   num_words = '0;
    logic              rewind = 1'b0;
    logic              card_ready = 1'b1;

    logic [ADDR_W-1:0] addr1, addr2, addr3;
    logic              clken1, clken2, clken3;
    logic              cs1, cs2, cs3;
    logic              we1, we2, we3;
    logic [31:0]       wdata1, wdata2, wdata3;
    logic [3:0]        be1, be2, be3;
    logic [31:0]       rdata1, rdata2, rdata3;
    logic              valid1, valid2, valid3;
    logic [7:0]        data1, data2, data3;
    logic [ADDR_W+1:0] idx1, idx2, idx3;
    logic              done1, done2, done3;
    logic [2:0]        dbg1, dbg2, dbg3;

    bj_card_sram_reader #(.ADDR_W(ADDR_W), .RD_LAT(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .init_done(init_done), .num_words(num_words),
        .rewind(rewind), .sram_address(addr1), .sram_clken(clken1), .sram_chipselect(cs1),
        .sram_write(we1), .sram_writedata(wdata1), .sram_byteenable(be1),
        .sram_readdata(rdata1), .card_valid(valid1), .card_data(data1),
        .card_ready(card_ready), .card_index(idx1), .deck_done(done1), .dbg_state(dbg1));

    bj_card_sram_reader #(.ADDR_W(ADDR_W), .RD_LAT(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .init_done(init_done), .num_words(num_words),
        .rewind(rewind), .sram_address(addr2), .sram_clken(clken2), .sram_chipselect(cs2),
        .sram_write(we2), .sram_writedata(wdata2), .sram_byteenable(be2),
        .sram_readdata(rdata2), .card_valid(valid2), .card_data(data2),
        .card_ready(card_ready), .card_index(idx2), .deck_done(done2), .dbg_state(dbg2));

    bj_card_sram_reader #(.ADDR_W(ADDR_W), .RD_LAT(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .init_done(init_done), .num_words(num_words),
        .rewind(rewind), .sram_address(addr3), .sram_clken(clken3), .sram_chipselect(cs3),
        .sram_write(we3), .sram_writedata(wdata3), .sram_byteenable(be3),
        .sram_readdata(rdata3), .card_valid(valid3), .card_data(data3),
        .card_ready(card_ready), .card_index(idx3), .deck_done(done3), .dbg_state(dbg3));

    // ---------------- SRAM models ----------------
    logic [31:0] mem [0:511];
    logic [31:0] p1_1;
    logic [31:0] p2_1, p2_2;
    logic [31:0] p3_1, p3_2, p3_3;

    always @(posedge clk) begin
        p1_1 <= cs1 ? mem[addr1] : $urandom;
        p2_1 <= cs2 ? mem[addr2] : $urandom;
        p2_2 <= p2_1;
        p3_1 <= cs3 ? mem[addr3] : $urandom;
        p3_2 <= p3_1;
        p3_3 <= p3_2;
    end
    assign rdata1 = p1_1;
    assign rdata2 = p2_2;
    assign rdata3 = p3_3;

    // ---------------- monitors ----------------
    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0]        exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [7:0]        c1_q[$], c2_q[$], c3_q[$];
    int                t1_q[$], t2_q[$], t3_q[$];
    logic [ADDR_W-1:0] cs2_q[$];
    int                cs1_n = 0;
    int                cs3_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid1 && card_ready) begin c1_q.push_back(data1); t1_q.push_back(cyc); end
        if (valid2 && card_ready) begin c2_q.push_back(data2); t2_q.push_back(cyc); end
        if (valid3 && card_ready) begin c3_q.push_back(data3); t3_q.push_back(cyc); end
        if (cs1) cs1_n <= cs1_n + 1;
        if (cs2) cs2_q.push_back(addr2);
        if (cs3) cs3_n <= cs3_n + 1;
    end

    // ---------------- reference model ----------------
    // Walk words 0..min(n,512)-1, bytes LSB first, stopping at the first zero.
    task automatic build_expected(input int n);
        int  last;
        bit  stop;
        logic [31:0] w;
        logic [7:0]  c;
        exp_q.delete();
        exp_addr_q.delete();
        last = (n > 512) ? 512 : n;
        stop = 1'b0;
        for (int a = 0; a < last && !stop; a++) begin
            exp_addr_q.push_back(9'(a));
            w = mem[a];
            for (int b = 0; b < 4 && !stop; b++) begin
                c = w[8*b +: 8];
                if (c == 8'h00) stop = 1'b1;
                else exp_q.push_back(c);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_idle();
        init_done = {7'($urandom), 1'b0};
        card_ready = 1'b1;
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
        tick();
    endtask

    task automatic raise_init();
        init_done = {7'($urandom), 1'b1};
    endtask

    task automatic drop_init();
        init_done = {7'($urandom), 1'b0};
    endtask

    task automatic run_until_done(input int budget, input bit rand_ready, input string name);
        int n;
        n = 0;
        while (!(done1 && done2 && done3) && n < budget) begin
            tick();
            if (rand_ready) card_ready = 1'($urandom_range(0, 1));
            n++;
        end
        card_ready = 1'b1;
        total++;
        if (!(done1 && done2 && done3)) begin
            bad++;
            $display("FAIL %s_timeout done=%b%b%b required=111", name, done1, done2, done3);
        end
    endtask

    task automatic load_basic();
        mem[0] = 32'h0403_0201;
        mem[1] = 32'h0807_0605;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (addr2 !== 9'd0 || cs2 !== 1'b0 || clken2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_sram addr=%0d cs=%b clken=%b required 0/0/0", addr2, cs2, clken2);
        end
        total++;
        if (valid2 !== 1'b0 || data2 !== 8'h00 || idx2 !== 11'd0 || done2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_card valid=%b data=%h idx=%0d done=%b required zeros",
                     valid2, data2, idx2, done2);
        end
        total++;
        if (we2 !== 1'b0 || wdata2 !== 32'h0 || be2 !== 4'hF) begin
            bad++;
            $display("FAIL reset_const we=%b wdata=%h be=%h required 0/0/f", we2, wdata2, be2);
        end
        reset_n = 1'b1;
        tick();
        total++;
        if (clken1 !== 1'b1 || clken2 !== 1'b1 || clken3 !== 1'b1) begin
            bad++;
            $display("FAIL clken_after_reset got=%b%b%b required=111", clken1, clken2, clken3);
        end
    endtask

    task automatic test_basic();
        int b2, bcs, nerr;
        sync_idle();
        load_basic();
        num_words = 10'd2;
        build_expected(2);
        b2 = c2_q.size();
        bcs = cs2_q.size();
        raise_init();
        run_until_done(200, 1'b0, "basic");
        nerr = 0;
        if (c2_q.size() - b2 != exp_q.size()) nerr = 99;
        else for (int i = 0; i < exp_q.size(); i++) if (c2_q[b2+i] !== exp_q[i]) nerr++;
        total++;
        if (nerr != 0) begin
            bad++;
            $display("FAIL basic_cards got_n=%0d errors=%0d required_n=%0d", c2_q.size() - b2, nerr, exp_q.size());
        end
        total++;
        if (cs2_q.size() - bcs != 2 || cs2_q[bcs] !== 9'd0 || cs2_q[bcs+1] !== 9'd1) begin
            bad++;
            $display("FAIL basic_reads got_n=%0d required 2 reads at 0,1", cs2_q.size() - bcs);
        end
        total++;
        if (idx2 !== 11'd8 || done2 !== 1'b1) begin
            bad++;
            $display("FAIL basic_index idx=%0d done=%b required 8/1", idx2, done2);
        end
        total++;
        if (t2_q.size() - b2 < 2 || t2_q[b2+1] - t2_q[b2] != 2) begin
            bad++;
            $display("FAIL basic_pace got_n=%0d required 2-cycle card spacing", t2_q.size() - b2);
        end
        drop_init();
        tick();
        total++;
        if (done2 !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_clear done=%b required=0", done2);
        end
    endtask

    task automatic test_zero_marker();
        int b2, bcs;
        sync_idle();
        mem[0] = 32'h0000_0B0A;
        mem[1] = 32'h1111_1111;
        num_words = 10'd4;
        b2 = c2_q.size();
        bcs = cs2_q.size();
        raise_init();
        run_until_done(200, 1'b0, "zero");
        total++;
        if (c2_q.size() - b2 != 2 || c2_q[b2] !== 8'h0A || c2_q[b2+1] !== 8'h0B) begin
            bad++;
            $display("FAIL zero_cards got_n=%0d required 0a,0b", c2_q.size() - b2);
        end
        total++;
        if (cs2_q.size() - bcs != 1 || idx2 !== 11'd2) begin
            bad++;
            $display("FAIL zero_reads reads=%0d idx=%0d required 1/2", cs2_q.size() - bcs, idx2);
        end
    endtask

    task automatic test_backpressure();
        int b2, nerr, n;
        bit held;
        sync_idle();
        load_basic();
        num_words = 10'd2;
        build_expected(2);
        b2 = c2_q.size();
        raise_init();
        held = 1'b0;
        n = 0;
        while (!held && n < 100) begin
            tick();
            n++;
            if (valid2 && data2 == 8'h03) begin
                held = 1'b1;
                card_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    total++;
                    if (valid2 !== 1'b1 || data2 !== 8'h03) begin
                        bad++;
                        $display("FAIL hold_card cycle=%0d valid=%b data=%h required 1/03", k, valid2, data2);
                    end
                end
                card_ready = 1'b1;
            end
        end
        run_until_done(200, 1'b0, "backpressure");
        nerr = 0;
        if (c2_q.size() - b2 != exp_q.size()) nerr = 99;
        else for (int i = 0; i < exp_q.size(); i++) if (c2_q[b2+i] !== exp_q[i]) nerr++;
        total++;
        if (nerr != 0 || !held) begin
            bad++;
            $display("FAIL hold_sequence got_n=%0d errors=%0d held=%b required 8 in order", c2_q.size() - b2, nerr, held);
        end
    endtask

    task automatic test_rewind();
        int b2, bcs, n, nerr;
        sync_idle();
        load_basic();
        num_words = 10'd2;
        b2 = c2_q.size();
        bcs = cs2_q.size();
        raise_init();
        n = 0;
        @(negedge clk);
        while (!(cs2 && addr2 == 9'd1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        tick();
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
        total++;
        if (valid2 !== 1'b0 || done2 !== 1'b0 || addr2 !== 9'd0 || idx2 !== 11'd4) begin
            bad++;
            $display("FAIL rewind_state valid=%b done=%b addr=%0d idx=%0d required 0/0/0/4",
                     valid2, done2, addr2, idx2);
        end
        repeat (10) tick();
        total++;
        if (c2_q.size() - b2 != 4 || cs2_q.size() - bcs != 2) begin
            bad++;
            $display("FAIL rewind_stale cards=%0d reads=%0d required 4/2", c2_q.size() - b2, cs2_q.size() - bcs);
        end
        drop_init();
        tick();
        build_expected(2);
        b2 = c2_q.size();
        bcs = cs2_q.size();
        raise_init();
        run_until_done(200, 1'b0, "rewind_restart");
        nerr = 0;
        if (c2_q.size() - b2 != exp_q.size()) nerr = 99;
        else for (int i = 0; i < exp_q.size(); i++) if (c2_q[b2+i] !== exp_q[i]) nerr++;
        total++;
        if (nerr != 0 || cs2_q[bcs] !== 9'd0) begin
            bad++;
            $display("FAIL rewind_restart got_n=%0d errors=%0d first_addr=%0d required 01..08 from 0",
                     c2_q.size() - b2, nerr, cs2_q[bcs]);
        end
    endtask

    task automatic test_empty();
        int bcs;
        sync_idle();
        num_words = 10'd0;
        bcs = cs2_q.size();
        raise_init();
        tick();
        total++;
        if (done2 !== 1'b1 || done1 !== 1'b1 || done3 !== 1'b1) begin
            bad++;
            $display("FAIL empty_done got=%b%b%b required=111", done1, done2, done3);
        end
        repeat (4) tick();
        drop_init();
        tick();
        total++;
        if (done2 !== 1'b0 || cs2_q.size() != bcs || valid2 !== 1'b0) begin
            bad++;
            $display("FAIL empty_idle done=%b reads=%0d valid=%b required 0/0/0", done2, cs2_q.size() - bcs, valid2);
        end
    endtask

    task automatic test_mid_deck_init();
        int b2, bcs;
        sync_idle();
        load_basic();
        num_words = 10'd2;
        b2 = c2_q.size();
        bcs = cs2_q.size();
        raise_init();
        repeat (4) tick();
        drop_init();
        repeat (3) tick();
        raise_init();
        run_until_done(200, 1'b0, "mid_init");
        repeat (5) tick();
        total++;
        if (c2_q.size() - b2 != 8 || cs2_q.size() - bcs != 2 || done2 !== 1'b1) begin
            bad++;
            $display("FAIL mid_init cards=%0d reads=%0d done=%b required 8/2/1", c2_q.size() - b2, cs2_q.size() - bcs, done2);
        end
    endtask

    task automatic test_latency();
        int b1, b2, b3, e1, e2, e3;
        sync_idle();
        load_basic();
        num_words = 10'd2;
        build_expected(2);
        b1 = c1_q.size(); b2 = c2_q.size(); b3 = c3_q.size();
        raise_init();
        run_until_done(200, 1'b0, "latency");
        e1 = 0; e2 = 0; e3 = 0;
        if (c1_q.size() - b1 != 8) e1 = 99;
        if (c2_q.size() - b2 != 8) e2 = 99;
        if (c3_q.size() - b3 != 8) e3 = 99;
        for (int i = 0; i < 8 && e1 + e2 + e3 == 0; i++) begin
            if (c1_q[b1+i] !== exp_q[i]) e1++;
            if (c2_q[b2+i] !== exp_q[i]) e2++;
            if (c3_q[b3+i] !== exp_q[i]) e3++;
        end
        total++;
        if (e1 + e2 + e3 != 0) begin
            bad++;
            $display("FAIL lat_cards errors l1=%0d l2=%0d l3=%0d required 0", e1, e2, e3);
        end
        if (e1 + e2 + e3 == 0) begin
            total++;
            if (t1_q[b1+4] - t1_q[b1+3] - 1 != 2) begin
                bad++;
                $display("FAIL lat1_gap got=%0d required=2", t1_q[b1+4] - t1_q[b1+3] - 1);
            end
            total++;
            if (t2_q[b2+4] - t2_q[b2+3] - 1 != 3) begin
                bad++;
                $display("FAIL lat2_gap got=%0d required=3", t2_q[b2+4] - t2_q[b2+3] - 1);
            end
            total++;
            if (t3_q[b3+4] - t3_q[b3+3] - 1 != 4) begin
                bad++;
                $display("FAIL lat3_gap got=%0d required=4", t3_q[b3+4] - t3_q[b3+3] - 1);
            end
        end
    endtask

    task automatic test_random_decks(input int iters, input bit clamp);
        int b1, b2, b3, bcs, n, nerr;
        logic [ADDR_W+1:0] exp_idx;
        for (int it = 0; it < iters; it++) begin
            sync_idle();
            n = clamp ? $urandom_range(513, 1023) : $urandom_range(1, 8);
            for (int a = 0; a < 512; a++) begin
                for (int b = 0; b < 4; b++) begin
                    if (!clamp && $urandom_range(0, 15) == 0) mem[a][8*b +: 8] = 8'h00;
                    else mem[a][8*b +: 8] = 8'($urandom_range(1, 255));
                end
            end
            num_words = 10'(n);
            build_expected(n);
            exp_idx = 11'(exp_q.size() % 2048);
            b1 = c1_q.size(); b2 = c2_q.size(); b3 = c3_q.size();
            bcs = cs2_q.size();
            raise_init();
            run_until_done(clamp ? 9000 : 2000, !clamp, clamp ? "clamp" : "random");
            nerr = 0;
            if (c1_q.size() - b1 != exp_q.size() || c2_q.size() - b2 != exp_q.size() ||
                c3_q.size() - b3 != exp_q.size()) nerr = 99999;
            else for (int i = 0; i < exp_q.size(); i++) begin
                if (c1_q[b1+i] !== exp_q[i]) nerr++;
                if (c2_q[b2+i] !== exp_q[i]) nerr++;
                if (c3_q[b3+i] !== exp_q[i]) nerr++;
            end
            total++;
            if (nerr != 0) begin
                bad++;
                $display("FAIL rand_cards iter=%0d n=%0d got_n=%0d errors=%0d required_n=%0d",
                         it, n, c2_q.size() - b2, nerr, exp_q.size());
            end
            nerr = 0;
            if (cs2_q.size() - bcs != exp_addr_q.size()) nerr = 99999;
            else for (int i = 0; i < exp_addr_q.size(); i++) if (cs2_q[bcs+i] !== exp_addr_q[i]) nerr++;
            total++;
            if (nerr != 0) begin
                bad++;
                $display("FAIL rand_reads iter=%0d got_n=%0d errors=%0d required_n=%0d",
                         it, cs2_q.size() - bcs, nerr, exp_addr_q.size());
            end
            total++;
            if (idx1 !== exp_idx || idx2 !== exp_idx || idx3 !== exp_idx) begin
                bad++;
                $display("FAIL rand_index iter=%0d got=%0d/%0d/%0d required=%0d", it, idx1, idx2, idx3, exp_idx);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        for (int a = 0; a < 512; a++) mem[a] = 32'h5A5A_5A5A;
        test_reset();
        test_basic();
        test_zero_marker();
        test_backpressure();
        test_rewind();
        test_empty();
        test_mid_deck_init();
        test_latency();
        test_random_decks(8, 1'b0);
        test_random_decks(1, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bj_card_sram_reader.md
Name: bj_card_sram_reader

Overview:
Fabric-side reader for the on-chip card SRAM. The HPS writes the shuffled deck into this SRAM through its own port. This block drives the SRAM's fabric-side s1 port (address/clken/chipselect/write/writedata/byteenable in, readdata out) as a read-only master. It starts when the HPS raises init_done bit 0, unpacks each 32-bit word into four 8-bit cards, and streams them to the blackjack engine over a valid/ready handshake.

Parameters:
ADDR_W, 9, SRAM word-address width; matches the 512-word card memory.
RD_LAT, 2, cycles from a chipselect cycle to valid sram_readdata; legal values 1..3.

Ports:
clk  in  1  system clock; same domain as the SRAM s1 port and the init_done PIO.
reset_n  in  1  asynchronous active-low reset.
init_done  in  8  HPS PIO; bit 0 = deck loaded; bits 7:1 ignored.
num_words  in  ADDR_W+1  number of valid deck words, 0..2^ADDR_W.
rewind  in  1  synchronous abort/restart pulse.
sram_address  out  ADDR_W  s1 word address.
sram_clken  out  1  s1 clock enable.
sram_chipselect  out  1  s1 chipselect (read strobe).
sram_write  out  1  s1 write; constant 0.
sram_writedata  out  32  constant 0.
sram_byteenable  out  4  constant 4'hF.
sram_readdata  in  32  s1 read data.
card_valid  out  1  card_data holds a card.
card_data  out  8  card code; 8'h00 = end-of-deck marker, never emitted.
card_ready  in  1  consumer accepts the card when card_valid && card_ready.
card_index  out  ADDR_W+2  count of cards accepted since start.
deck_done  out  1  deck exhausted.

Behaviour:
- Reset (async, reset_n low): state IDLE, sram_address=0, sram_clken=0, sram_chipselect=0, card_valid=0, card_data=0, card_index=0, deck_done=0. sram_write, sram_writedata and sram_byteenable hold their constants at all times.
- sram_clken=1 in every cycle after reset deassertion.
- Start condition: rising edge of init_done[0], detected against a 1-cycle registered copy. No synchronizer is needed because the PIO is in the same clock domain.
- States:
  - IDLE: wait for the start condition. On start: if num_words==0, go to DONE; otherwise clear sram_address and card_index and go to ISSUE.
  - ISSUE: assert sram_chipselect for exactly 1 cycle with the current sram_address, then go to WAIT.
  - WAIT: count RD_LAT cycles after the chipselect cycle. In the cycle when the count reaches RD_LAT, sample sram_readdata into word_reg, set byte_sel=0, and go to STREAM.
  - STREAM: present byte byte_sel of word_reg, LSB first (bits 7:0 first, then 15:8, 23:16, 31:24).
    - If that byte is 8'h00: go to DONE without asserting card_valid for it.
    - Otherwise: card_valid=1 and card_data=byte. card_data stays stable while card_valid && !card_ready.
    - On accept: card_index++. If byte_sel<3, byte_sel++ and present the next byte in the following cycle. If byte_sel==3: if sram_address==num_words-1, go to DONE; else sram_address++ and go to ISSUE.
  - DONE: card_valid=0, deck_done=1. Return to IDLE when init_done[0]==0; deck_done clears on that transition.
- card_valid drops in the cycle after each accept, so there is at most 1 card per 2 cycles within a word. Per-word overhead is 1+RD_LAT cycles.
- There is never more than one outstanding SRAM read.
- rewind: has priority over all other transitions.
  - From any state, go to IDLE next cycle with card_valid=0, deck_done=0, sram_address=0. card_index holds its value until the next start.
  - A read in flight is discarded: its returned data is never sampled.
  - If init_done[0] is still high after rewind, a fresh 0->1 edge is required to restart.
- Start edge while not in IDLE: ignored.
- num_words > 2^ADDR_W: treated as 2^ADDR_W. The last word address is 2^ADDR_W-1; there is no wrap.
- init_done[0] falling mid-deck: ignored. Streaming continues to DONE.

Test Plan:
- Memory words 0x04030201, 0x08070605, num_words=2, card_ready tied 1, pulse init_done 0->1 -> cards 1,2,3,4,5,6,7,8 in order; exactly 2 chipselect cycles at addresses 0 and 1; deck_done=1; card_index=8.
- Word 0 = 0x00000B0A, num_words=4 -> cards 0x0A, 0x0B, then DONE; no read at address 1; card_index=2.
- card_ready held 0 for 5 cycles on card 0x03 -> card_valid stays 1 and card_data stays 0x03 throughout; accepted once; no duplicate or dropped card.
- rewind asserted in the cycle after the chipselect at address 1 -> card_valid=0 next cycle; the stale readdata is not emitted. A new init_done edge restarts from address 0 with card 0x01.
- num_words=0 with start edge -> no chipselect; deck_done=1 after 1 cycle. Drop init_done[0] -> deck_done=0, back in IDLE.
- RD_LAT=1 and RD_LAT=3 builds with a memory model of matching latency -> identical card sequence 0x01..0x08. Word-to-word gap is 2 cycles (RD_LAT=1) and 4 cycles (RD_LAT=3).
